// File: rtl/csr_file.sv
// Floating-point status (fflags/frm/fcsr) and machine counter CSRs.
// Combinational read/fault decode; state commits on the rising edge of i_clk.
module csr_file #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_FLAG_SRC = 2,
    parameter int unsigned RETIRE_W     = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_csr_en,
    input  logic [11:0]                     i_csr_addr,
    input  logic [1:0]                      i_csr_op,
    input  logic                            i_csr_write,
    input  logic [XLEN-1:0]                 i_wr_data,
    input  logic [NUM_FLAG_SRC-1:0]         i_fflags_valid,
    input  logic [5*NUM_FLAG_SRC-1:0]       i_fflags,
    input  logic [$clog2(RETIRE_W+1)-1:0]   i_retire_cnt,
    output logic [XLEN-1:0]                 o_rd_data,
    output logic                            o_illegal,
    output logic [2:0]                      o_frm,
    output logic                            o_frm_rsvd
);

    localparam int unsigned RCW    = $clog2(RETIRE_W + 1);
    localparam bit          HAS_HI = (XLEN == 32);

    localparam logic [11:0] A_FFLAGS   = 12'h001;
    localparam logic [11:0] A_FRM      = 12'h002;
    localparam logic [11:0] A_FCSR     = 12'h003;
    localparam logic [11:0] A_MCNTINH  = 12'h320;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTRH   = 12'hC82;

    logic [4:0]      fflags_q, fflags_d;
    logic [2:0]      frm_q, frm_d;
    logic            cy_inh_q, cy_inh_d;
    logic            ir_inh_q, ir_inh_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic            hit;
    logic [XLEN-1:0] rd_val;
    logic            wr_eff;
    logic [XLEN-1:0] new_val;
    logic [4:0]      acc;
    logic [RCW-1:0]  ret_clamp;

    // Address decode and read mux
    always_comb begin
        hit    = 1'b1;
        rd_val = '0;
        case (i_csr_addr)
            A_FFLAGS:              rd_val = XLEN'(fflags_q);
            A_FRM:                 rd_val = XLEN'(frm_q);
            A_FCSR:                rd_val = XLEN'({frm_q, fflags_q});
            A_MCNTINH:             rd_val = XLEN'({ir_inh_q, 1'b0, cy_inh_q});
            A_MCYCLE, A_CYCLE:     rd_val = XLEN'(mcycle_q);
            A_MINSTRET, A_INSTRET: rd_val = XLEN'(minstret_q);
            A_MCYCLEH, A_CYCLEH: begin
                hit    = HAS_HI;
                rd_val = HAS_HI ? XLEN'(mcycle_q[63:32]) : '0;
            end
            A_MINSTRH, A_INSTRH: begin
                hit    = HAS_HI;
                rd_val = HAS_HI ? XLEN'(minstret_q[63:32]) : '0;
            end
            default:               hit = 1'b0;
        endcase
    end

    assign o_rd_data  = (i_csr_en && hit) ? rd_val : '0;
    assign o_illegal  = i_csr_en & (~hit | (i_csr_write & (i_csr_op != 2'b11)
                                            & (i_csr_addr[11:8] == 4'hC)));
    assign wr_eff     = i_csr_en & i_csr_write & (i_csr_op != 2'b11) & ~o_illegal;
    assign o_frm      = frm_q;
    assign o_frm_rsvd = (frm_q >= 3'd5);

    // Read-modify-write operand
    always_comb begin
        new_val = o_rd_data;
        case (i_csr_op)
            2'b00:   new_val = i_wr_data;
            2'b01:   new_val = o_rd_data | i_wr_data;
            2'b10:   new_val = o_rd_data & ~i_wr_data;
            default: new_val = o_rd_data;
        endcase
    end

    // Next-state: accrued flags are ORed after the write so clears never drop them
    always_comb begin
        acc        = '0;
        fflags_d   = fflags_q;
        frm_d      = frm_q;
        cy_inh_d   = cy_inh_q;
        ir_inh_d   = ir_inh_q;
        ret_clamp  = (i_retire_cnt > RCW'(RETIRE_W)) ? RCW'(RETIRE_W) : i_retire_cnt;
        mcycle_d   = cy_inh_q ? mcycle_q : mcycle_q + 64'd1;
        minstret_d = ir_inh_q ? minstret_q : minstret_q + 64'(ret_clamp);

        for (int k = 0; k < int'(NUM_FLAG_SRC); k++) begin
            if (i_fflags_valid[k]) begin
                acc = acc | i_fflags[5*k +: 5];
            end
        end

        if (wr_eff) begin
            case (i_csr_addr)
                A_FFLAGS:   fflags_d = new_val[4:0];
                A_FRM:      frm_d    = new_val[2:0];
                A_FCSR: begin
                    fflags_d = new_val[4:0];
                    frm_d    = new_val[7:5];
                end
                A_MCNTINH: begin
                    cy_inh_d = new_val[0];
                    ir_inh_d = new_val[2];
                end
                A_MCYCLE:   mcycle_d   = (XLEN == 64) ? 64'(new_val)
                                                      : {mcycle_q[63:32], new_val[31:0]};
                A_MINSTRET: minstret_d = (XLEN == 64) ? 64'(new_val)
                                                      : {minstret_q[63:32], new_val[31:0]};
                A_MCYCLEH:  mcycle_d   = {new_val[31:0], mcycle_q[31:0]};
                A_MINSTRH:  minstret_d = {new_val[31:0], minstret_q[31:0]};
                default:    ;
            endcase
        end

        fflags_d = fflags_d | acc;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fflags_q   <= '0;
            frm_q      <= '0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            fflags_q   <= fflags_d;
            frm_q      <= frm_d;
            cy_inh_q   <= cy_inh_d;
            ir_inh_q   <= ir_inh_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file (XLEN=32): decode table, directed corner
// sequences and randomized traffic compared against a behavioural model.
module tb_csr_file;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            csr_en;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic            csr_write;
    logic [XLEN-1:0] wr_data;
    logic [1:0]      fflags_valid;
    logic [9:0]      fflags;
    logic [1:0]      retire_cnt;
    logic [XLEN-1:0] rd_data;
    logic            illegal;
    logic [2:0]      frm;
    logic            frm_rsvd;

    csr_file #(.XLEN(XLEN), .NUM_FLAG_SRC(2), .RETIRE_W(2)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_csr_en       (csr_en),
        .i_csr_addr     (csr_addr),
        .i_csr_op       (csr_op),
        .i_csr_write    (csr_write),
        .i_wr_data      (wr_data),
        .i_fflags_valid (fflags_valid),
        .i_fflags       (fflags),
        .i_retire_cnt   (retire_cnt),
        .o_rd_data      (rd_data),
        .o_illegal      (illegal),
        .o_frm          (frm),
        .o_frm_rsvd     (frm_rsvd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic        m_cy, m_ir;
    logic [63:0] m_mcycle, m_minstret;

    // Values sampled in the most recent cycle
    logic [XLEN-1:0] s_rd;
    logic            s_ill;
    logic [2:0]      s_frm;
    logic            s_rsvd;

    typedef struct {
        logic        en;
        logic [11:0] addr;
        logic [1:0]  op;
        logic        wr;
        logic        exp_ill;
        logic        rd_zero;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic m_mapped(input logic [11:0] a);
        case (a)
            12'h001, 12'h002, 12'h003, 12'h320,
            12'hB00, 12'hB02, 12'hC00, 12'hC02,
            12'hB80, 12'hB82, 12'hC80, 12'hC82: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_value(input logic [11:0] a);
        logic [63:0] ctr;
        ctr = a[1] ? m_minstret : m_mcycle;
        if (a == 12'h001) return 64'(m_fflags);
        if (a == 12'h002) return 64'(m_frm);
        if (a == 12'h003) return 64'(m_frm) * 32 + 64'(m_fflags);
        if (a == 12'h320) return 64'(m_cy) + 64'(m_ir) * 4;
        if (!m_mapped(a)) return 64'd0;
        return a[7] ? (ctr >> 32) : (ctr & 64'hFFFF_FFFF);
    endfunction

    task automatic m_reset();
        m_fflags = '0; m_frm = '0; m_cy = 1'b0; m_ir = 1'b0;
        m_mcycle = '0; m_minstret = '0;
    endtask

    // One clock cycle: drive just after a falling edge, check, advance model, return at next falling edge
    task automatic cycle(input logic en, input logic [11:0] a, input logic [1:0] op,
                         input logic wr, input logic [31:0] wd, input logic [1:0] fv,
                         input logic [9:0] ff, input logic [1:0] rc);
        logic        mapped, ill, eff;
        logic [63:0] old, nv, wd64;
        logic [4:0]  acc;
        logic [63:0] rcc;
        csr_en = en; csr_addr = a; csr_op = op; csr_write = wr; wr_data = wd;
        fflags_valid = fv; fflags = ff; retire_cnt = rc;
        #1;
        s_rd = rd_data; s_ill = illegal; s_frm = frm; s_rsvd = frm_rsvd;

        mapped = m_mapped(a);
        old    = m_value(a);
        ill    = en && (!mapped || (wr && op != 2'b11 && a >= 12'hC00 && a <= 12'hCFF));
        check("rd_data", 64'(s_rd), (en && mapped) ? old : 64'd0);
        check("illegal", 64'(s_ill), 64'(ill));
        check("frm", 64'(s_frm), 64'(m_frm));
        check("frm_rsvd", 64'(s_rsvd), 64'(m_frm >= 3'd5));

        eff  = en && wr && op != 2'b11 && !ill;
        wd64 = 64'(wd);
        case (op)
            2'b00:   nv = wd64;
            2'b01:   nv = old | wd64;
            default: nv = old & ~wd64;
        endcase
        acc = '0;
        for (int k = 0; k < 2; k++) if (fv[k]) acc = acc | 5'((ff >> (5 * k)) % 32);
        rcc = (rc > 2'd2) ? 64'd2 : 64'(rc);

        if (eff && (a == 12'h001 || a == 12'h003)) m_fflags = 5'(nv % 32) | acc;
        else                                       m_fflags = m_fflags | acc;
        if (eff && a == 12'h002) m_frm = 3'(nv % 8);
        if (eff && a == 12'h003) m_frm = 3'((nv / 32) % 8);

        if      (eff && a == 12'hB00) m_mcycle = (m_mcycle & 64'hFFFF_FFFF_0000_0000) | (nv & 64'hFFFF_FFFF);
        else if (eff && a == 12'hB80) m_mcycle = (m_mcycle & 64'hFFFF_FFFF) | ((nv & 64'hFFFF_FFFF) << 32);
        else if (!m_cy)               m_mcycle = m_mcycle + 1;
        if      (eff && a == 12'hB02) m_minstret = (m_minstret & 64'hFFFF_FFFF_0000_0000) | (nv & 64'hFFFF_FFFF);
        else if (eff && a == 12'hB82) m_minstret = (m_minstret & 64'hFFFF_FFFF) | ((nv & 64'hFFFF_FFFF) << 32);
        else if (!m_ir)               m_minstret = m_minstret + rcc;

        if (eff && a == 12'h320) begin
            m_cy = nv[0];
            m_ir = nv[2];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] rc);
        cycle(1'b0, 12'h000, 2'b11, 1'b0, 32'h0, 2'b00, 10'h0, rc);
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                          input logic [1:0] rc);
        cycle(1'b1, a, op, 1'b1, wd, 2'b00, 10'h0, rc);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        cycle(1'b1, a, 2'b11, 1'b0, 32'h0, 2'b00, 10'h0, 2'd0);
        check(name, 64'(s_rd), 64'(exp));
    endtask

    task automatic do_reset();
        csr_en = 1'b1; csr_addr = 12'h001; csr_op = 2'b11; csr_write = 1'b0;
        wr_data = '0; fflags_valid = '0; fflags = '0; retire_cnt = '0;
        rst_n = 1'b0;
        #1;
        check("reset_rd", 64'(rd_data), 64'd0);
        check("reset_frm", 64'(frm), 64'd0);
        check("reset_rsvd", 64'(frm_rsvd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[15];
        logic [11:0] addr_pool[15];
        logic [11:0] chk_addr[2];

        // Reset then 10 idle cycles: both counter views read 10
        chk_addr[0] = 12'hB00;
        chk_addr[1] = 12'hC00;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < 10; i++) idle(2'd0);
            rd_chk("cycle_after_10", chk_addr[r], 32'd10);
        end
        rd_chk("fflags_after_reset", 12'h001, 32'h0);

        // Same-cycle RC clear and flag accrual
        cycle(1'b1, 12'h001, 2'b10, 1'b1, 32'h1F, 2'b11, {5'h01, 5'h04}, 2'd0);
        rd_chk("fflags_rc_accrue", 12'h001, 32'h05);

        // fcsr write sets frm to reserved 6 and all flags
        wr_csr(12'h003, 2'b00, 32'hDF, 2'd0);
        rd_chk("fflags_via_fcsr", 12'h001, 32'h1F);
        check("frm_is_6", 64'(s_frm), 64'd6);
        check("frm_rsvd_set", 64'(s_rsvd), 64'd1);
        wr_csr(12'h002, 2'b00, 32'h0, 2'd0);
        rd_chk("fflags_kept", 12'h001, 32'h1F);
        check("frm_rsvd_clear", 64'(s_rsvd), 64'd0);

        // Low-half carry into high half, read-only write faults
        wr_csr(12'hB80, 2'b00, 32'h0, 2'd0);
        wr_csr(12'hB00, 2'b00, 32'hFFFF_FFFF, 2'd0);
        idle(2'd0);
        rd_chk("mcycle_lo_carry", 12'hB00, 32'h0);
        rd_chk("mcycle_hi_carry", 12'hB80, 32'h1);
        wr_csr(12'hC00, 2'b00, 32'h55, 2'd0);
        check("ro_write_illegal", 64'(s_ill), 64'd1);
        check("ro_write_rd", 64'(s_rd), 64'd2);
        rd_chk("mcycle_unchanged", 12'hB00, 32'd3);

        // Instret inhibit: write cycle still counts with old inhibit
        wr_csr(12'h320, 2'b01, 32'h4, 2'd2);
        for (int i = 0; i < 5; i++) idle(2'd2);
        rd_chk("minstret_inhibited", 12'hB02, 32'd2);
        rd_chk("mcycle_counting", 12'hB00, 32'd11);
        wr_csr(12'h320, 2'b10, 32'h4, 2'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 12'hB02, 2'b11, 1'b0, 32'h0, 2'b00, 10'h0, 2'd2);
            check("minstret_plus2", 64'(s_rd), 64'(2 + 2 * i));
        end
        cycle(1'b1, 12'hB02, 2'b11, 1'b0, 32'h0, 2'b00, 10'h0, 2'd3);
        check("minstret_pre_clamp", 64'(s_rd), 64'd8);
        rd_chk("minstret_clamped", 12'hB02, 32'd10);

        // 64-bit wrap of both counters
        wr_csr(12'hB80, 2'b00, 32'hFFFF_FFFF, 2'd0);
        wr_csr(12'hB00, 2'b00, 32'hFFFF_FFFF, 2'd0);
        idle(2'd0);
        rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
        wr_csr(12'hB82, 2'b00, 32'hFFFF_FFFF, 2'd2);
        wr_csr(12'hB02, 2'b00, 32'hFFFF_FFFF, 2'd2);
        idle(2'd2);
        rd_chk("minstret_wrap_lo", 12'hB02, 32'h1);
        rd_chk("minstret_wrap_hi", 12'hB82, 32'h0);

        // Decode / fault table
        vecs[0]  = '{1'b1, 12'h001, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 12'h005, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 12'hC00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 12'hC00, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 12'hC80, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 12'hC02, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 12'hB82, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 12'h321, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 12'h7FF, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 12'hC00, 2'b00, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 12'hC01, 2'b11, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 12'h000, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 12'h320, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 12'hCFF, 2'b11, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 12'hB01, 2'b00, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].en, vecs[i].addr, vecs[i].op, vecs[i].wr, 32'hA5A5_5A5A,
                  2'b00, 10'h0, 2'd1);
            check($sformatf("tbl_illegal[%0d]", i), 64'(s_ill), 64'(vecs[i].exp_ill));
            if (vecs[i].rd_zero) check($sformatf("tbl_rd_zero[%0d]", i), 64'(s_rd), 64'd0);
        end

        // Randomized traffic against the model
        addr_pool = '{12'h001, 12'h002, 12'h003, 12'h320, 12'hB00, 12'hB02, 12'hC00,
                      12'hC02, 12'hB80, 12'hB82, 12'hC80, 12'hC82, 12'h004, 12'hC01, 12'h7FF};
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), addr_pool[$urandom_range(0, 14)],
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                  2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
                  2'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-sequence
        wr_csr(12'h320, 2'b00, 32'h0, 2'd0);
        wr_csr(12'hB82, 2'b00, 32'h0, 2'd0);
        wr_csr(12'hB02, 2'b00, 32'h7, 2'd0);
        wr_csr(12'h002, 2'b00, 32'h3, 2'd0);
        csr_en = 1'b1; csr_addr = 12'hB02; csr_op = 2'b11; csr_write = 1'b0;
        retire_cnt = 2'd0; fflags_valid = '0;
        #1;
        check("pre_reset_minstret", 64'(rd_data), 64'd7);
        check("pre_reset_frm", 64'(frm), 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_minstret", 64'(rd_data), 64'd0);
        check("async_reset_frm", 64'(frm), 64'd0);
        check("async_reset_rsvd", 64'(frm_rsvd), 64'd0);
        csr_addr = 12'h002;
        #1;
        check("async_reset_frm_rd", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL provide parameter NUM_FLAG_SRC, default 2, number of FP result ports reporting exception flags per cycle.
REQ-003 SHALL provide parameter RETIRE_W, default 2, maximum instructions retired per cycle.
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_csr_en  input  1  CSR instruction access this cycle.
REQ-007 SHALL have port i_csr_addr  input  12  CSR address.
REQ-008 SHALL have port i_csr_op  input  2  00 RW, 01 RS, 10 RC, 11 read-only.
REQ-009 SHALL have port i_csr_write  input  1  write request, ignored when i_csr_en=0.
REQ-010 SHALL have port i_wr_data  input  XLEN  operand (rs1 value or zero-extended zimm).
REQ-011 SHALL have port i_fflags_valid  input  NUM_FLAG_SRC  per-port flag valid.
REQ-012 SHALL have port i_fflags  input  5*NUM_FLAG_SRC  port k in [5k+4:5k], order nv,dz,of,uf,nx MSB first.
REQ-013 SHALL have port i_retire_cnt  input  $clog2(RETIRE_W+1)  instructions retired this cycle.
REQ-014 SHALL have port o_rd_data  output  XLEN  read data.
REQ-015 SHALL have port o_illegal  output  1  access fault.
REQ-016 SHALL have port o_frm  output  3  current rounding mode.
REQ-017 SHALL have port o_frm_rsvd  output  1  frm holds reserved encoding 5, 6 or 7.

Function
REQ-018 SHALL map: 0x001 fflags; 0x002 frm; 0x003 fcsr = {frm,fflags} in bits 7:0; 0x320 mcountinhibit (bit0 CY, bit2 IR, other bits read 0); 0xB00/0xB02 mcycle/minstret; 0xC00/0xC02 read-only shadows cycle/instret; when XLEN=32 also upper halves 0xB80/0xB82/0xC80/0xC82.
REQ-019 SHALL read combinationally: o_rd_data = addressed CSR zero-extended; 0 when i_csr_en=0 or address unmapped.
REQ-020 SHALL drive o_illegal combinationally = i_csr_en & (unmapped address | (i_csr_write & op!=11 & address in 0xC00-0xCFF)); upper-half addresses are unmapped when XLEN=64.
REQ-021 SHALL define effective write = i_csr_en & i_csr_write & op!=11 & !o_illegal; new value RW = i_wr_data, RS = old|i_wr_data, RC = old&~i_wr_data, with old = o_rd_data.
REQ-022 SHALL commit an effective write at the next rising edge; bits outside implemented fields are discarded.
REQ-023 SHALL compute acc = OR of all i_fflags slices whose valid bit is set; each edge fflags <= base|acc, where base = written value on effective write to 0x001/0x003, else current fflags.
REQ-024 SHALL never lose same-cycle accumulated flags, including when RC or RW clears the same bit.
REQ-025 SHALL change frm only on effective write to 0x002 or 0x003; o_frm = frm; o_frm_rsvd = (frm>=5), combinational.
REQ-026 SHALL increment 64-bit mcycle by 1 per edge when CY=0, and minstret by i_retire_cnt when IR=0, clamping i_retire_cnt to RETIRE_W.
REQ-027 SHALL wrap counters modulo 2^64 (2^64-1 +1 -> 0; minstret multi-increment wraps likewise).
REQ-028 SHALL, on effective write to a counter half, replace that half, hold the other half, and suppress that counter's increment that cycle.
REQ-029 SHALL apply mcountinhibit writes at the next edge; counting in the write cycle uses the old inhibit value.
REQ-030 SHALL return pre-increment counter values on reads in the current cycle.

Reset
REQ-031 SHALL, while i_rst_n=0, asynchronously hold frm, fflags, mcountinhibit, mcycle and minstret at 0, giving o_frm=0 and o_frm_rsvd=0; o_rd_data/o_illegal follow REQ-019/020.
REQ-032 SHALL apply the first mcycle increment on the first rising edge after i_rst_n deasserts; reset deassertion is synchronised to i_clk outside the block.

Verification
REQ-033 Bench SHALL check: reset, 10 idle cycles, read 0xB00 -> 10; read 0xC00 -> 10; read 0x001 -> 0.
REQ-034 Bench SHALL check: same cycle RC 0x001 with wr_data=0x1F, port0 valid with flags 0x04, port1 valid with 0x01 -> fflags=0x05 next cycle.
REQ-035 Bench SHALL check: RW 0x003 with 0xDF -> o_frm=6, o_frm_rsvd=1, fflags=0x1F; then RW 0x002 with 0 -> o_frm_rsvd=0, fflags still 0x1F.
REQ-036 Bench SHALL check (XLEN=32): write 0xB80=0, 0xB00=0xFFFFFFFF, then idle 1 cycle -> read 0xB80=1, 0xB00=0; write 0xC00 -> o_illegal=1, counter unchanged.
REQ-037 Bench SHALL check: RS 0x320 with 0x4, then i_retire_cnt=2 for 5 cycles -> minstret unchanged while mcycle keeps counting; RC 0x320 with 0x4 -> minstret +2 per cycle.
REQ-038 Bench SHALL check: assert i_rst_n low mid-sequence with minstret=7, frm=3 -> both 0 immediately, before any clock edge.
